// File: rtl/bus_owner_arbiter_if.sv
// Bus-owner handshake bundle between the requesting sources and the arbiter
// that drives the tri-state mux select.
interface bus_owner_arbiter_if;
  logic [2:0] req;
  logic [2:0] sel;
  logic [2:0] gnt;
  logic       bus_idle;

  // Arbiter side: samples requests, drives select/grant/idle.
  modport master (
    input  req,
    output sel,
    output gnt,
    output bus_idle
  );

  // Source/mux side: raises requests, observes the owner.
  modport slave (
    output req,
    input  sel,
    input  gnt,
    input  bus_idle
  );
endinterface

// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for a 3-source tri-state bus mux.
// Drives a registered 3-bit select code and a one-hot grant, inserts
// GUARD_CYC all-off cycles between two different owners so that two bufif1
// drivers never overlap, and caps a grant at MAX_HOLD cycles while another
// source is waiting.
module bus_owner_arbiter #(
  parameter int unsigned MAX_HOLD  = 8,  // 2..255
  parameter int unsigned GUARD_CYC = 1   // 1..15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_owner_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD_C  = MAX_HOLD[7:0];
  localparam logic [3:0] GUARD_CYC_C = GUARD_CYC[3:0];

  state_t     state_q,     state_d;
  logic [1:0] owner_q,     owner_d;
  logic [1:0] rr_ptr_q,    rr_ptr_d;
  logic [7:0] hold_cnt_q,  hold_cnt_d;
  logic [3:0] guard_cnt_q, guard_cnt_d;
  logic [2:0] sel_q,       sel_d;
  logic [2:0] gnt_q,       gnt_d;
  logic       bus_idle_q,  bus_idle_d;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [2:0] owner_mask;
  logic       owner_req;
  logic       other_req;

  // Next index in round-robin order (mod 3).
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Select code for an owner: 0->001, 1->010, 2->011; sel[2] is never set.
  function automatic logic [2:0] sel_code(input logic [1:0] idx);
    return {1'b0, idx + 2'd1};
  endfunction

  // One-hot grant for an owner.
  function automatic logic [2:0] gnt_code(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  // First asserted request starting at ptr and walking ptr, ptr+1, ptr+2.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    cand  = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = rr_next(cand);
    end
    return {found, idx};
  endfunction

  assign {win_vld, win_idx} = rr_pick(bus.req, rr_ptr_q);
  assign owner_mask         = gnt_code(owner_q);
  assign owner_req          = |(bus.req & owner_mask);
  assign other_req          = |(bus.req & ~owner_mask);

  // Next-state logic: arbitration, hold capping and guard sequencing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    guard_cnt_d = guard_cnt_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;

    case (state_q)
      ST_IDLE: begin
        // Bus already floats, so a winner is granted without a guard gap.
        if (win_vld) begin
          state_d    = ST_OWN;
          owner_d    = win_idx;
          rr_ptr_d   = rr_next(win_idx);
          hold_cnt_d = 8'd1;
          sel_d      = sel_code(win_idx);
          gnt_d      = gnt_code(win_idx);
        end
      end

      ST_OWN: begin
        if (!owner_req || (hold_cnt_q == MAX_HOLD_C && other_req)) begin
          // Release (voluntary or forced rotation): float the bus first.
          state_d     = ST_GUARD;
          guard_cnt_d = 4'd1;
          hold_cnt_d  = 8'd0;
          sel_d       = 3'b000;
          gnt_d       = 3'b000;
        end else if (hold_cnt_q == MAX_HOLD_C) begin
          // Nobody else waiting: keep the owner and restart the window.
          hold_cnt_d = 8'd1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      ST_GUARD: begin
        // Requests are only looked at on the final guard edge.
        if (guard_cnt_q >= GUARD_CYC_C) begin
          guard_cnt_d = 4'd0;
          if (win_vld) begin
            state_d    = ST_OWN;
            owner_d    = win_idx;
            rr_ptr_d   = rr_next(win_idx);
            hold_cnt_d = 8'd1;
            sel_d      = sel_code(win_idx);
            gnt_d      = gnt_code(win_idx);
          end else begin
            state_d = ST_IDLE;
            sel_d   = 3'b000;
            gnt_d   = 3'b000;
          end
        end else begin
          guard_cnt_d = guard_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        hold_cnt_d  = 8'd0;
        guard_cnt_d = 4'd0;
        sel_d       = 3'b000;
        gnt_d       = 3'b000;
      end
    endcase

    bus_idle_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset floats the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
      hold_cnt_q  <= 8'd0;
      guard_cnt_q <= 4'd0;
      sel_q       <= 3'b000;
      gnt_q       <= 3'b000;
      bus_idle_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      bus_idle_q  <= bus_idle_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.gnt      = gnt_q;
  assign bus.bus_idle = bus_idle_q;

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Directed bench for bus_owner_arbiter: reset, single grant, round-robin
// rotation with hold capping, lone requester, 3-cycle guard, asynchronous
// reset mid-grant, then random requests checked against the bus invariants.
module tb_bus_owner_arbiter;

  logic clk;
  logic rst_n;

  bus_owner_arbiter_if bi  ();
  bus_owner_arbiter_if bi3 ();

  bus_owner_arbiter #(.MAX_HOLD(8), .GUARD_CYC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bi.master)
  );

  bus_owner_arbiter #(.MAX_HOLD(8), .GUARD_CYC(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bi3.master)
  );

  int n_checks;
  int n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [2:0] o_sel, input logic [2:0] o_gnt, input logic o_idle,
                         input logic [2:0] e_sel, input logic [2:0] e_gnt, input logic e_idle);
    check_val({tag, ".sel"},  {5'd0, o_sel},  {5'd0, e_sel});
    check_val({tag, ".gnt"},  {5'd0, o_gnt},  {5'd0, e_gnt});
    check_val({tag, ".idle"}, {7'd0, o_idle}, {7'd0, e_idle});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_sel(input int o);
    return 3'(o + 1);
  endfunction

  function automatic logic [2:0] exp_gnt(input int o);
    return 3'(1 << o);
  endfunction

  // Grant implied by a select code (000 -> no grant).
  function automatic logic [2:0] gnt_from_sel(input logic [2:0] s);
    logic [2:0] g;
    case (s)
      3'b001:  g = 3'b001;
      3'b010:  g = 3'b010;
      3'b011:  g = 3'b100;
      default: g = 3'b000;
    endcase
    return g;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk_out("rst", bi.sel, bi.gnt, bi.bus_idle, 3'b000, 3'b000, 1'b1);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic invariants(input string tag, input logic [2:0] s, input logic [2:0] g,
                            inout logic [2:0] prev);
    logic bad_jump;
    check_val({tag, ".sel2"},   {7'd0, s[2]}, 8'd0);
    check_val({tag, ".onehot"}, {7'd0, $onehot0(g)}, 8'd1);
    check_val({tag, ".gnt"},    {5'd0, g}, {5'd0, gnt_from_sel(s)});
    bad_jump = (prev != 3'b000) && (s != 3'b000) && (prev != s);
    check_val({tag, ".jump"},   {7'd0, bad_jump}, 8'd0);
    prev = s;
  endtask

  initial begin
    logic [2:0] prev_a;
    logic [2:0] prev_b;
    int order [4];
    n_checks = 0;
    n_errors = 0;
    bi.req   = 3'b000;
    bi3.req  = 3'b000;
    rst_n    = 1'b1;
    #1;

    // Reset state
    do_reset();
    chk_out("rst_rel", bi.sel, bi.gnt, bi.bus_idle, 3'b000, 3'b000, 1'b1);

    // Test 1: single grant, release, guard, idle
    bi.req = 3'b010;
    tick();
    chk_out("t1_own", bi.sel, bi.gnt, bi.bus_idle, 3'b010, 3'b010, 1'b0);
    bi.req = 3'b000;
    tick();
    chk_out("t1_guard", bi.sel, bi.gnt, bi.bus_idle, 3'b000, 3'b000, 1'b0);
    tick();
    chk_out("t1_idle", bi.sel, bi.gnt, bi.bus_idle, 3'b000, 3'b000, 1'b1);

    // Test 2: all request, rotation 0,1,2,0 with 8-cycle holds
    do_reset();
    order = '{0, 1, 2, 0};
    bi.req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        chk_out($sformatf("t2_o%0d_c%0d", r, c), bi.sel, bi.gnt, bi.bus_idle,
                exp_sel(order[r]), exp_gnt(order[r]), 1'b0);
      end
      if (r < 3) begin
        tick();
        chk_out($sformatf("t2_gap%0d", r), bi.sel, bi.gnt, bi.bus_idle, 3'b000, 3'b000, 1'b0);
      end
    end
    bi.req = 3'b000;
    tick();
    chk_out("t2_guard", bi.sel, bi.gnt, bi.bus_idle, 3'b000, 3'b000, 1'b0);
    tick();
    chk_out("t2_idle", bi.sel, bi.gnt, bi.bus_idle, 3'b000, 3'b000, 1'b1);

    // Test 3: lone requester keeps the bus past MAX_HOLD without gaps
    bi.req = 3'b100;
    tick();
    check_val("t3_first", {5'd0, bi.sel}, 8'h03);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val($sformatf("t3_c%0d", c), {5'd0, bi.sel}, 8'h03);
    end
    bi.req = 3'b000;
    tick();
    tick();
    check_val("t3_idle", {7'd0, bi.bus_idle}, 8'h01);

    // Test 5: asynchronous reset mid-grant
    bi.req = 3'b100;
    tick();
    check_val("t5_own", {5'd0, bi.sel}, 8'h03);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t5_async", bi.sel, bi.gnt, bi.bus_idle, 3'b000, 3'b000, 1'b1);
    tick();
    rst_n  = 1'b1;
    bi.req = 3'b001;
    tick();
    chk_out("t5_after", bi.sel, bi.gnt, bi.bus_idle, 3'b001, 3'b001, 1'b0);
    bi.req = 3'b000;

    // Test 4: GUARD_CYC=3 gives exactly three all-off cycles
    bi3.req = 3'b011;
    tick();
    chk_out("t4_own0", bi3.sel, bi3.gnt, bi3.bus_idle, 3'b001, 3'b001, 1'b0);
    bi3.req = 3'b010;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("t4_guard%0d", c), bi3.sel, bi3.gnt, bi3.bus_idle, 3'b000, 3'b000, 1'b0);
      bi3.req = (c == 0) ? 3'b000 : 3'b010;
    end
    tick();
    chk_out("t4_own1", bi3.sel, bi3.gnt, bi3.bus_idle, 3'b010, 3'b010, 1'b0);

    // Test 6: random requests against the bus invariants
    prev_a = bi.sel;
    prev_b = bi3.sel;
    for (int n = 0; n < 400; n++) begin
      bi.req  = 3'($urandom_range(0, 7));
      bi3.req = 3'($urandom_range(0, 7));
      tick();
      invariants("t6a", bi.sel, bi.gnt, prev_a);
      invariants("t6b", bi3.sel, bi3.gnt, prev_b);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
